// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts 12-bit instructions, holds a 4x4 register file and sequences the external 4-bit ALU
// Ports: instr/instr_valid/instr_ready instruction handshake; alu_en/alu_op1/alu_op2/alu_opc drive the ALU,
// alu_res/alu_carry return its result; carry_flag/done/div0 report status; dbg_sel/dbg_data peek the register file.
module alu_issue_ctrl #(
  parameter int NREG = 4,
  parameter int DW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [11:0]   instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic          alu_en,
  output logic [DW-1:0] alu_op1,
  output logic [DW-1:0] alu_op2,
  output logic [1:0]    alu_opc,
  input  logic [DW-1:0] alu_res,
  input  logic          alu_carry,
  output logic          carry_flag,
  output logic          done,
  output logic          div0,
  input  logic [1:0]    dbg_sel,
  output logic [DW-1:0] dbg_data
);
  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;
  state_t        state_q, state_d;
  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [DW-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [1:0]    opc_q, opc_d, rd_q, rd_d;
  logic          carry_q, carry_d, done_q, done_d, div0_q, div0_d;
  logic          div_zero;
  // a divide whose divisor is already zero is trapped here and never reaches the ALU
  assign div_zero = instr[10:9] == 2'b11 && regs_q[instr[4:3]] == '0;
  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    opc_d   = opc_q;
    rd_d    = rd_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    div0_d  = 1'b0;
    if (state_q == IDLE && instr_valid) begin
      if (instr[11]) begin
        regs_d[instr[8:7]] = instr[DW-1:0];
        done_d = 1'b1;
      end else if (div_zero) begin
        regs_d[instr[8:7]] = '1;
        carry_d = 1'b1;
        done_d  = 1'b1;
        div0_d  = 1'b1;
      end else begin
        op1_d   = regs_q[instr[6:5]];
        op2_d   = regs_q[instr[4:3]];
        opc_d   = instr[10:9];
        rd_d    = instr[8:7];
        state_d = ISSUE;
      end
    end else if (state_q == ISSUE) begin
      state_d = WB;
    end else if (state_q == WB) begin
      regs_d[rd_q] = alu_res;
      carry_d = alu_carry;
      done_d  = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      regs_q  <= '{default: '0};
      op1_q   <= '0;
      op2_q   <= '0;
      opc_q   <= '0;
      rd_q    <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      opc_q   <= opc_d;
      rd_q    <= rd_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
    end
  end
  assign instr_ready = state_q == IDLE;
  assign alu_en      = state_q == ISSUE;
  assign alu_op1     = op1_q;
  assign alu_op2     = op2_q;
  assign alu_opc     = opc_q;
  assign carry_flag  = carry_q;
  assign done        = done_q;
  assign div0        = div0_q;
  assign dbg_data    = regs_q[dbg_sel];
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed table, hand-written corner sequences and random instructions against a reference model
module tb_alu_issue_ctrl;
  logic        clk = 0, rst = 1;
  logic [11:0] instr = '0;
  logic        instr_valid = 0;
  logic        instr_ready, alu_en, alu_carry = 0, carry_flag, done, div0;
  logic [3:0]  alu_op1, alu_op2, alu_res = '0, dbg_data;
  logic [1:0]  alu_opc, dbg_sel = '0;
  int tests = 0, fails = 0, en_cnt = 0;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .alu_en(alu_en), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opc(alu_opc),
    .alu_res(alu_res), .alu_carry(alu_carry), .carry_flag(carry_flag), .done(done), .div0(div0),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // stand-in for the 4-bit ALU: samples on the falling edge while enabled, holds its result otherwise
  always @(negedge clk) begin
    logic [4:0] t;
    logic [7:0] p;
    if (alu_en) begin
      en_cnt++;
      t = '0;
      p = {4'b0, alu_op1} * {4'b0, alu_op2};
      if (alu_opc == 2'd0) t = {1'b0, alu_op1} + {1'b0, alu_op2};
      else if (alu_opc == 2'd1) t = {1'b0, alu_op1} - {1'b0, alu_op2};
      else if (alu_opc == 2'd2) t = {1'b0, p[3:0]};
      else t = {1'b0, (alu_op2 != 0) ? alu_op1 / alu_op2 : 4'hF};
      alu_res = t[3:0];
      alu_carry = (alu_opc[1] == 1'b0) ? t[4] : 1'b0;
    end
  end

  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  function automatic logic [11:0] ldi(input logic [1:0] rd, input logic [3:0] imm);
    return {1'b1, 2'b00, rd, 3'b000, imm};
  endfunction

  function automatic logic [11:0] aop(input logic [1:0] opc, input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2);
    return {1'b0, opc, rd, rs1, rs2, 3'b000};
  endfunction

  task automatic rd_reg(input logic [1:0] r, output logic [3:0] v);
    dbg_sel = r;
    #1;
    v = dbg_data;
  endtask

  task automatic send(input logic [11:0] w);
    int n;
    instr = w;
    instr_valid = 1;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: instr_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    instr_valid = 0;
  endtask

  task automatic run_instr(input logic [11:0] w, input logic [1:0] r, input logic [3:0] v,
                           input logic c, input logic d0, input logic alu);
    int e0;
    logic [3:0] got;
    e0 = en_cnt;
    send(w);
    if (alu) begin
      chk("issue_ready", instr_ready, 0);
      chk("issue_done", done, 0);
      @(posedge clk);
      #1;
      chk("wb_ready", instr_ready, 0);
      chk("wb_en", alu_en, 0);
      @(posedge clk);
      #1;
    end
    chk("done", done, 1);
    chk("div0", div0, d0);
    chk("ready", instr_ready, 1);
    chk("carry", carry_flag, c);
    chk("en_pulses", en_cnt - e0, alu);
    rd_reg(r, got);
    chk($sformatf("reg%0d", r), got, v);
    @(posedge clk);
    #1;
    chk("done_end", done, 0);
  endtask

  typedef struct {
    logic [11:0] w;
    logic [1:0]  r;
    logic [3:0]  v;
    logic        c;
    logic        d0;
    logic        alu;
  } vec_t;
  vec_t tbl[13];

  logic [3:0] m[4];
  logic       mc;

  initial begin
    logic [3:0] got;
    bit seen;
    tbl[0]  = '{ldi(1, 9), 1, 4'h9, 0, 0, 0};
    tbl[1]  = '{ldi(2, 8), 2, 4'h8, 0, 0, 0};
    tbl[2]  = '{aop(0, 3, 1, 2), 3, 4'h1, 1, 0, 1};
    tbl[3]  = '{ldi(0, 3), 0, 4'h3, 1, 0, 0};
    tbl[4]  = '{ldi(1, 5), 1, 4'h5, 1, 0, 0};
    tbl[5]  = '{aop(1, 2, 0, 1), 2, 4'hE, 1, 0, 1};
    tbl[6]  = '{aop(1, 3, 1, 0), 3, 4'h2, 0, 0, 1};
    tbl[7]  = '{ldi(1, 7), 1, 4'h7, 0, 0, 0};
    tbl[8]  = '{ldi(2, 3), 2, 4'h3, 0, 0, 0};
    tbl[9]  = '{aop(2, 3, 1, 2), 3, 4'h5, 0, 0, 1};
    tbl[10] = '{aop(3, 0, 1, 2), 0, 4'h2, 0, 0, 1};
    tbl[11] = '{ldi(2, 0), 2, 4'h0, 0, 0, 0};
    tbl[12] = '{aop(3, 3, 1, 2), 3, 4'hF, 1, 1, 0};

    #12;
    chk("rst_ready", instr_ready, 1);
    chk("rst_en", alu_en, 0);
    chk("rst_ops", {alu_op1, alu_op2, alu_opc}, 0);
    chk("rst_flags", {carry_flag, done, div0}, 0);
    for (int i = 0; i < 4; i++) begin
      rd_reg(2'(i), got);
      chk("rst_reg", got, 0);
    end
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++)
      run_instr(tbl[i].w, tbl[i].r, tbl[i].v, tbl[i].c, tbl[i].d0, tbl[i].alu);

    // valid held across two dependent words: second word waits through ISSUE and WB, accepted once
    run_instr(ldi(1, 4), 1, 4'h4, 1, 0, 0);
    run_instr(ldi(2, 5), 2, 4'h5, 1, 0, 0);
    begin
      int e0;
      e0 = en_cnt;
      instr = aop(0, 3, 1, 2);
      instr_valid = 1;
      @(posedge clk); #1;
      chk("b2b_issue_ready", instr_ready, 0);
      chk("b2b_issue_en", alu_en, 1);
      instr = aop(1, 0, 3, 1);
      @(posedge clk); #1;
      chk("b2b_wb_ready", instr_ready, 0);
      chk("b2b_wb_en", alu_en, 0);
      @(posedge clk); #1;
      chk("b2b_ready_back", instr_ready, 1);
      chk("b2b_done1", done, 1);
      rd_reg(3, got);
      chk("b2b_r3", got, 9);
      @(posedge clk); #1;
      chk("b2b_second_accept", instr_ready, 0);
      instr_valid = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("b2b_done2", done, 1);
      rd_reg(0, got);
      chk("b2b_r0", got, 5);
      chk("b2b_carry", carry_flag, 0);
      chk("b2b_en_pulses", en_cnt - e0, 2);
      @(posedge clk); #1;
    end

    // reset in ISSUE aborts the instruction
    send(aop(0, 2, 1, 1));
    chk("abort_in_issue", alu_en, 1);
    rst = 1;
    #1;
    chk("abort_ready", instr_ready, 1);
    chk("abort_en", alu_en, 0);
    chk("abort_flags", {carry_flag, done, div0}, 0);
    for (int i = 0; i < 4; i++) begin
      rd_reg(2'(i), got);
      chk("abort_reg", got, 0);
    end
    @(negedge clk);
    rst = 0;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      seen |= done;
    end
    chk("abort_no_done", seen, 0);
    run_instr(ldi(2, 4'hA), 2, 4'hA, 0, 0, 0);

    m = '{4'h0, 4'h0, 4'hA, 4'h0};
    mc = 0;
    for (int k = 0; k < 300; k++) begin
      logic [11:0] w;
      logic [1:0] rd;
      int a, b, res, c, d0, alu;
      w = 12'($urandom);
      w[11] = ($urandom_range(0, 2) == 0);
      rd = w[8:7];
      d0 = 0;
      alu = 1;
      c = 0;
      if (w[11]) begin
        res = w[3:0];
        c = mc;
        alu = 0;
      end else begin
        a = m[w[6:5]];
        b = m[w[4:3]];
        case (w[10:9])
          2'd0: begin res = (a + b) % 16; c = (a + b) / 16; end
          2'd1: begin res = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
          2'd2: res = (a * b) % 16;
          default: begin
            if (b == 0) begin res = 15; c = 1; d0 = 1; alu = 0; end
            else res = a / b;
          end
        endcase
      end
      m[rd] = 4'(res);
      mc = c[0];
      run_instr(w, rd, 4'(res), c[0], d0[0], alu[0]);
    end
    for (int i = 0; i < 4; i++) begin
      rd_reg(2'(i), got);
      chk("final_reg", got, m[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue controller that drives the 4-bit processor ALU. It accepts 12-bit instruction words over a valid/ready handshake and holds a 4×4-bit register file. For each instruction it reads the source registers, presents `op1`/`op2`/`opc`/`enable` to the ALU, and writes the ALU's `res` and `carry` back to the destination register and the carry flag. It sits between the instruction source and the ALU; this block is the initiator, the ALU is the responder.

## Interface
Parameters:
- `NREG`, 4: register-file depth. Fixed at 4 by the 2-bit register fields.
- `DW`, 4: data width. Must match the ALU operand width.

Ports:
- `clk`  in  1  system clock; registers update on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `instr`  in  12  instruction word, valid while `instr_valid` is high.
- `instr_valid`  in  1  instruction present.
- `instr_ready`  out  1  controller can accept an instruction this cycle.
- `alu_en`  out  1  drives the ALU `enable` input.
- `alu_op1`  out  4  drives the ALU `op1` input.
- `alu_op2`  out  4  drives the ALU `op2` input.
- `alu_opc`  out  2  drives the ALU `opc` input (00 add, 01 sub, 10 mul, 11 div).
- `alu_res`  in  4  ALU `res` output.
- `alu_carry`  in  1  ALU `carry` output.
- `carry_flag`  out  1  carry from the last ALU or div-by-zero writeback.
- `done`  out  1  one-cycle pulse when an instruction retires.
- `div0`  out  1  one-cycle pulse when a divide-by-zero is trapped.
- `dbg_sel`  in  2  register-file read select.
- `dbg_data`  out  4  combinational `regs[dbg_sel]`.

## Operation
Instruction format:
- `instr[11]` = 1: LDI. Writes `regs[instr[8:7]] <= instr[3:0]`.
- `instr[11]` = 0: ALU operation. Fields are `opc=instr[10:9]`, `rd=instr[8:7]`, `rs1=instr[6:5]`, `rs2=instr[4:3]`. `instr[2:0]` is ignored.

State machine: IDLE, ISSUE, WB.
- **IDLE:** `instr_ready`=1. Handshake completes when `instr_valid && instr_ready` at a rising edge.
  - LDI: write the register, pulse `done` next cycle, stay in IDLE.
  - ALU op with `opc`=11 and `regs[rs2]`=0: do not issue. Write `regs[rd] <= 4'hF` and `carry_flag <= 1`. Pulse `done` and `div0` next cycle. Stay in IDLE.
  - Other ALU op: register `alu_op1 <= regs[rs1]`, `alu_op2 <= regs[rs2]`, `alu_opc <= opc`, `alu_en <= 1`. Latch `rd`. Go to ISSUE.
- **ISSUE:** `instr_ready`=0, `alu_en`=1. The ALU computes on this cycle's falling edge. Go to WB.
- **WB:** `alu_en`=0, `instr_ready`=0. At the rising edge leaving WB: `regs[rd] <= alu_res`, `carry_flag <= alu_carry`, `done` pulses in the following cycle. Go to IDLE.
- `alu_op1`, `alu_op2` and `alu_opc` hold their values after ISSUE until the next issue.
- Operands are always read from the register file at acceptance. Writeback finishes before the next acceptance, so back-to-back dependent instructions see the updated value; no forwarding is needed.
- `rd` may equal `rs1` or `rs2`. The source values are already captured, so this is safe.
- `carry_flag` is untouched by LDI.
- Arithmetic is whatever the ALU returns:
  - add: carry is bit 4 of the sum.
  - sub: carry is the borrow bit, i.e. bit 4 of the 5-bit difference.
  - mul: low 4 bits, carry 0.
  - div: integer quotient, carry 0.
- The controller never modifies `alu_res`.

## Timing
- Reset (asynchronous, immediate): state=IDLE, all `regs`=0, `instr_ready`=1, `alu_en`=0, `alu_op1`=`alu_op2`=0, `alu_opc`=00, `carry_flag`=0, `done`=0, `div0`=0.
- Reset asserted during ISSUE or WB aborts the instruction: no writeback and no `done`.
- LDI and div-by-zero: accepted at edge N; the register update is visible at N; `done` is high in cycle N..N+1; `instr_ready` stays 1. Throughput is 1 per cycle.
- ALU op: accepted at edge N. `alu_en` is high from N to N+1. The ALU samples on the falling edge between N and N+1. WB writes at N+2, `done` is high N+2..N+3, and `instr_ready` is back to 1 from N+2. Throughput is 1 per 2 cycles.
- `instr_valid` held high while `instr_ready`=0 is ignored. The same word is accepted once `instr_ready` returns to 1. The source must hold `instr` stable until accepted.
- `alu_en` is never high for more than one consecutive cycle.

## Test plan
- LDI r1=9, LDI r2=8, then ADD r3=r1+r2 → r3=1, `carry_flag`=1, `alu_en` high exactly one cycle, `done` two cycles after acceptance.
- LDI r0=3, LDI r1=5, then SUB r2=r0-r1 → r2=4'hE, `carry_flag`=1. Then SUB r3=r1-r0 → r3=2, `carry_flag`=0.
- r1=7, r2=3: MUL r3 → r3=5 (21 mod 16), carry 0. DIV r0=r1/r2 → r0=2, carry 0.
- r2=0, DIV r3=r1/r2 → no `alu_en` pulse, r3=4'hF, `carry_flag`=1, `div0` and `done` pulse together, `instr_ready` never drops.
- Hold `instr_valid`=1 with two different words back-to-back → `instr_ready` low for exactly the ISSUE and WB cycles, second word accepted once, dependent read (`rs1`=previous `rd`) sees the new value.
- Assert `rst` during ISSUE → all registers 0, no `done`, `carry_flag`=0, `instr_ready`=1 immediately. A following LDI works normally.
